// File: rtl/bitonic_stream_driver.sv
// Serial-to-block front end for one bitonic sort block: packs N elements, starts the
// sorter, waits for done (with optional timeout), then replays the sorted block serially.
module bitonic_stream_driver #(
    parameter int DATA_WIDTH     = 8,
    parameter int BLOCK_DEPTH    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [DATA_WIDTH-1:0]                    in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [(2**BLOCK_DEPTH)*DATA_WIDTH-1:0]   sort_data,
    output logic                                     sort_valid,
    input  logic                                     sort_done,
    input  logic [(2**BLOCK_DEPTH)*DATA_WIDTH-1:0]   sort_result,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     timeout_err
);

    localparam int N       = 2 ** BLOCK_DEPTH;
    localparam int T_WIDTH = N * DATA_WIDTH;
    localparam int IDX_W   = $clog2(N) + 1;
    localparam int WC_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [WC_W-1:0]        wait_cnt_r;
    logic [T_WIDTH-1:0]     pack_r;
    logic [T_WIDTH-1:0]     result_r;
    logic                   in_ready_r;
    logic                   sort_valid_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic                   busy_r;
    logic                   timeout_err_r;

    logic [IDX_W-1:0]       idx_inc_s;
    logic                   idx_last_s;
    logic                   next_last_s;
    logic [DATA_WIDTH-1:0]  next_elem_s;

    function automatic logic [DATA_WIDTH-1:0] pick_elem(input logic [T_WIDTH-1:0] vec,
                                                        input logic [IDX_W-1:0]   k);
        logic [DATA_WIDTH-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e = (k == IDX_W'(i)) ? vec[i*DATA_WIDTH +: DATA_WIDTH] : e;
        end
        return e;
    endfunction

    // Index arithmetic and the element that follows the one currently presented.
    always_comb begin
        idx_inc_s   = idx_r + IDX_W'(1);
        idx_last_s  = (idx_r == IDX_LAST);
        next_last_s = (idx_inc_s == IDX_LAST);
        next_elem_s = pick_elem(result_r, idx_inc_s);
    end

    // Block-level FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FILL;
            idx_r         <= '0;
            wait_cnt_r    <= '0;
            pack_r        <= '0;
            result_r      <= '0;
            in_ready_r    <= 1'b1;
            sort_valid_r  <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= '0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (idx_r == IDX_W'(i)) begin
                                pack_r[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                            end
                        end
                        if (idx_last_s) begin
                            state_r      <= ISSUE;
                            idx_r        <= '0;
                            in_ready_r   <= 1'b0;
                            sort_valid_r <= 1'b1;
                            busy_r       <= 1'b1;
                        end else begin
                            idx_r <= idx_inc_s;
                        end
                    end
                end
                ISSUE: begin
                    state_r      <= WAIT;
                    idx_r        <= '0;
                    sort_valid_r <= 1'b0;
                    wait_cnt_r   <= '0;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (sort_done) begin
                        state_r     <= DRAIN;
                        idx_r       <= '0;
                        result_r    <= sort_result;
                        out_data_r  <= sort_result[DATA_WIDTH-1:0];
                        out_valid_r <= 1'b1;
                        out_last_r  <= (IDX_LAST == IDX_W'(0));
                    end else if (TO_EN && (wait_cnt_r == WC_LAST)) begin
                        state_r       <= FILL;
                        idx_r         <= '0;
                        timeout_err_r <= 1'b1;
                        in_ready_r    <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WC_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_last_s) begin
                            state_r     <= FILL;
                            idx_r       <= '0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= '0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            idx_r      <= idx_inc_s;
                            out_data_r <= next_elem_s;
                            out_last_r <= next_last_s;
                        end
                    end
                end
                default: begin
                    state_r      <= FILL;
                    idx_r        <= '0;
                    in_ready_r   <= 1'b1;
                    sort_valid_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                    out_last_r   <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign sort_data   = pack_r;
    assign sort_valid  = sort_valid_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_bitonic_stream_driver.sv
// Directed bench: a 2-element driver with a short timeout plus a 4-element driver
// streamed with random handshake gaps, each paired with a small sort-block model.
module tb_bitonic_stream_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 1: DW=8, BD=1, TIMEOUT=4
    logic [7:0]  in_data1;
    logic        in_valid1, in_ready1;
    logic [15:0] sort_data1, sort_result1, sres1;
    logic        sort_valid1, sort_done1, sdone1, spur1, hang1;
    logic [7:0]  out_data1;
    logic        out_valid1, out_ready1, out_last1, busy1, terr1;

    // Instance 2: DW=8, BD=2, default timeout
    logic [7:0]  in_data2;
    logic        in_valid2, in_ready2;
    logic [31:0] sort_data2, sres2;
    logic        sort_valid2, sdone2, sv2_d;
    logic [7:0]  out_data2;
    logic        out_valid2, out_ready2, out_last2, busy2, terr2;

    assign sort_done1   = sdone1 | spur1;
    assign sort_result1 = sres1;

    bitonic_stream_driver #(.DATA_WIDTH(8), .BLOCK_DEPTH(1), .TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sort_data(sort_data1), .sort_valid(sort_valid1),
        .sort_done(sort_done1), .sort_result(sort_result1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_last(out_last1), .busy(busy1), .timeout_err(terr1)
    );

    bitonic_stream_driver #(.DATA_WIDTH(8), .BLOCK_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .sort_data(sort_data2), .sort_valid(sort_valid2),
        .sort_done(sdone2), .sort_result(sres2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .busy(busy2), .timeout_err(terr2)
    );

    function automatic logic [15:0] sort2(input logic [15:0] v);
        return (v[7:0] <= v[15:8]) ? v : {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] sort4(input logic [31:0] v);
        logic [7:0] a [4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
        for (int p = 0; p < 3; p++)
            for (int j = 0; j < 3; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return {a[3], a[2], a[1], a[0]};
    endfunction

    // Sort block model 1: done one cycle after start unless hung.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sdone1 <= 1'b0;
            sres1  <= 16'h0000;
        end else begin
            sdone1 <= sort_valid1 & ~hang1;
            if (sort_valid1) sres1 <= sort2(sort_data1);
        end
    end

    // Sort block model 2: done two cycles after start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sv2_d  <= 1'b0;
            sdone2 <= 1'b0;
            sres2  <= 32'h0;
        end else begin
            sv2_d  <= sort_valid2;
            sdone2 <= sv2_d;
            if (sort_valid2) sres2 <= sort4(sort_data2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents two elements back to back; returns just after the ISSUE edge.
    task automatic feed1(input logic [7:0] a, input logic [7:0] b);
        in_valid1 = 1'b1;
        in_data1  = a;
        tick();
        in_data1  = b;
        tick();
        in_valid1 = 1'b0;
    endtask

    logic [7:0] vin  [12] = '{8'h40, 8'h10, 8'h30, 8'h20, 8'hFF, 8'h00,
                              8'h80, 8'h7F, 8'h05, 8'h05, 8'h01, 8'h09};
    logic [7:0] vexp [12] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h7F,
                              8'h80, 8'hFF, 8'h01, 8'h05, 8'h05, 8'h09};

    initial begin
        int pi, oi, svc;
        reset = 1'b1;
        in_data1 = 8'h00; in_valid1 = 1'b0; out_ready1 = 1'b0;
        spur1 = 1'b0; hang1 = 1'b0;
        in_data2 = 8'h00; in_valid2 = 1'b0; out_ready2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_sort_valid", sort_valid1, 0);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_out_last", out_last1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_terr", terr1, 0);
        chk("rst_sort_data", sort_data1, 0);

        // 1 Basic
        out_ready1 = 1'b1;
        feed1(8'h05, 8'h03);
        chk("t1_sort_valid", sort_valid1, 1);
        chk("t1_sort_data", sort_data1, 32'h0305);
        chk("t1_in_ready", in_ready1, 0);
        chk("t1_busy", busy1, 1);
        tick();
        chk("t1_wait_sv", sort_valid1, 0);
        chk("t1_wait_data", sort_data1, 32'h0305);
        chk("t1_wait_ov", out_valid1, 0);
        tick();
        chk("t1_ov0", out_valid1, 1);
        chk("t1_od0", out_data1, 32'h03);
        chk("t1_ol0", out_last1, 0);
        tick();
        chk("t1_od1", out_data1, 32'h05);
        chk("t1_ol1", out_last1, 1);
        chk("t1_ir_drain", in_ready1, 0);
        tick();
        chk("t1_end_ov", out_valid1, 0);
        chk("t1_end_ir", in_ready1, 1);
        chk("t1_end_busy", busy1, 0);

        // 2 Backpressure, with in_valid asserted while busy
        out_ready1 = 1'b0;
        feed1(8'h05, 8'h03);
        in_valid1 = 1'b1;
        in_data1  = 8'hEE;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_ov", out_valid1, 1);
            chk("t2_hold_od", out_data1, 32'h03);
            chk("t2_hold_ir", in_ready1, 0);
            tick();
        end
        chk("t2_held_od", out_data1, 32'h03);
        out_ready1 = 1'b1;
        in_valid1  = 1'b0;
        tick();
        chk("t2_od1", out_data1, 32'h05);
        chk("t2_ol1", out_last1, 1);
        chk("t2_ir1", in_ready1, 0);
        tick();
        chk("t2_end_ov", out_valid1, 0);
        chk("t2_end_ir", in_ready1, 1);

        // 4 Spurious done in FILL, then a clean block
        spur1 = 1'b1;
        tick();
        spur1 = 1'b0;
        chk("t4_ir", in_ready1, 1);
        chk("t4_busy", busy1, 0);
        chk("t4_ov", out_valid1, 0);
        chk("t4_terr", terr1, 0);
        feed1(8'h40, 8'h30);
        chk("t4_sort_data", sort_data1, 32'h3040);
        tick();
        tick();
        chk("t4_od0", out_data1, 32'h30);
        tick();
        chk("t4_od1", out_data1, 32'h40);
        chk("t4_ol1", out_last1, 1);
        tick();

        // 3 Timeout
        hang1 = 1'b1;
        feed1(8'h11, 8'h22);
        chk("t3_sort_data", sort_data1, 32'h2211);
        for (int k = 0; k < 4; k++) tick();
        chk("t3_wait_busy", busy1, 1);
        chk("t3_wait_terr", terr1, 0);
        chk("t3_wait_ir", in_ready1, 0);
        tick();
        chk("t3_terr", terr1, 1);
        chk("t3_ir", in_ready1, 1);
        chk("t3_busy", busy1, 0);
        chk("t3_ov", out_valid1, 0);
        hang1 = 1'b0;
        feed1(8'h09, 8'h01);
        tick();
        tick();
        chk("t3_od0", out_data1, 32'h01);
        chk("t3_terr_sticky", terr1, 1);
        tick();
        chk("t3_od1", out_data1, 32'h09);
        tick();
        chk("t3_terr_end", terr1, 1);

        // 5 Reset mid-DRAIN
        feed1(8'h07, 8'h02);
        tick();
        tick();
        chk("t5_od0", out_data1, 32'h02);
        tick();
        chk("t5_od1", out_data1, 32'h07);
        reset = 1'b1;
        #1;
        chk("t5_rst_ov", out_valid1, 0);
        chk("t5_rst_ir", in_ready1, 1);
        chk("t5_rst_terr", terr1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        feed1(8'h0A, 8'h0B);
        chk("t5_sort_data", sort_data1, 32'h0B0A);
        tick();
        tick();
        chk("t5_n_od0", out_data1, 32'h0A);
        tick();
        chk("t5_n_od1", out_data1, 32'h0B);
        chk("t5_n_ol1", out_last1, 1);
        tick();

        // 6 Streaming, 4-element blocks with random handshake gaps
        pi = 0; oi = 0; svc = 0;
        for (int cyc = 0; cyc < 600 && oi < 12; cyc++) begin
            in_valid2  = (pi < 12) && ($urandom_range(0, 3) != 0);
            in_data2   = (pi < 12) ? vin[pi] : 8'h00;
            out_ready2 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (sort_valid2) svc++;
            if (in_valid2 && in_ready2) pi++;
            if (out_valid2 && out_ready2) begin
                chk($sformatf("t6_od%0d", oi), out_data2, vexp[oi]);
                chk($sformatf("t6_ol%0d", oi), out_last2, ((oi % 4) == 3) ? 1 : 0);
                oi++;
            end
            @(posedge clk);
            #1;
        end
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        chk("t6_out_count", oi, 12);
        chk("t6_in_count", pi, 12);
        chk("t6_sort_valid_count", svc, 3);
        chk("t6_terr", terr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
